prod_ratio_unit: RTL

PROD_RATIO_UNIT -- requirements
Module: prod_ratio_unit

---
 rtl/prod_ratio_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/prod_ratio_unit.sv
// Product / ratio engine: captures a,b,c,d, forms a*b and c*d, then either returns the
// product or divides a*b by c*d with a bit-serial restoring divider.
//
// state | meaning
// IDLE  | waiting for start, operands not yet captured
// MUL   | forming both products, choosing product / div-by-zero / divide path
// DIV   | one restoring-division step per cycle, MSB of the dividend first
// FIN   | results registers just updated, done pulse visible
module prod_ratio_unit #(
    parameter int W  = 16,
    parameter int CW = $clog2(2*W) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [W-1:0]    c,
    input  logic [W-1:0]    d,
    output logic            busy,
    output logic            done,
    output logic [2*W-1:0]  quot,
    output logic [2*W-1:0]  rem,
    output logic            dz
);

    localparam int DW = 2 * W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic            mode_q, mode_d;
    logic [DW-1:0]   num_q, num_d;
    logic [DW-1:0]   den_q, den_d;
    logic [DW-1:0]   prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic            dz_q, dz_d, busy_q, busy_d, done_q, done_d;

    logic [DW-1:0]   prod_ab, prod_cd;
    logic [DW:0]     trial, diff;

    assign prod_ab = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    assign prod_cd = {{W{1'b0}}, c_q} * {{W{1'b0}}, d_q};

    // Partial remainder is always below den, so one extra bit holds the shifted value.
    assign trial = {prem_q, num_q[DW-1]};
    assign diff  = trial - {1'b0, den_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        mode_d  = mode_q;
        num_d   = num_q;
        den_d   = den_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    d_d     = d;
                    mode_d  = mode;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                num_d = prod_ab;
                den_d = prod_cd;
                if (mode_q) begin
                    quot_d  = prod_ab;
                    rem_d   = '0;
                    dz_d    = 1'b0;
                    state_d = S_FIN;
                end else if (prod_cd == '0) begin
                    quot_d  = '1;
                    rem_d   = prod_ab;
                    dz_d    = 1'b1;
                    state_d = S_FIN;
                end else begin
                    prem_d  = '0;
                    cnt_d   = CW'(DW);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Quotient bits shift into the bottom of num as dividend bits leave the top.
                prem_d = diff[DW] ? trial[DW-1:0] : diff[DW-1:0];
                num_d  = {num_q[DW-2:0], ~diff[DW]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = num_d;
                    rem_d   = prem_d;
                    dz_d    = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            num_q   <= '0;
            den_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            den_q   <= den_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
    assign dz   = dz_q;

endmodule
